uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command sequencer behind the UART receiver. Consumes received bytes (data + finished_read strobe),
//  frames them into fixed 4-byte packets (SYNC, HDR, DATA, CHK), validates checksum and inter-byte
//  timeout, and issues single-cycle register writes to a 16-entry config space. Owns the RX
//  error counter; sits between uart_receive and the design's config registers.
// PARAMETERS
//  CLK_HZ         5_000_000  system clock frequency (Hz)
//  BAUD           9600       UART bit rate
//  TIMEOUT_BYTES  2          inter-byte timeout, in byte times (10 bits each)
//  SYNC_BYTE      8'hA5      packet start marker
//  (local) TIMEOUT_CYCLES = (CLK_HZ/BAUD)*10*TIMEOUT_BYTES, integer division; defaults -> 520*10*2 = 10400
// PORTS
//  clock        in   1  system clock, rising edge
//  reset_n      in   1  asynchronous active-low reset
//  rx_data      in   8  received byte from receiver (valid while rx_valid high)
//  rx_valid     in   1  receiver finished_read; may be held >1 cycle, byte taken on rising edge only
//  reg_wr_en    out  1  one-cycle register write strobe
//  reg_addr     out  4  write address (HDR[3:0])
//  reg_wr_data  out  8  write data
//  pkt_ok       out  1  one-cycle pulse: packet accepted and executed
//  pkt_err      out  1  one-cycle pulse: checksum/unknown-cmd/timeout error
//  busy         out  1  high while state != IDLE
//  err_count    out  8  saturating error count
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; timeout counter 0; rx_valid history 0.
//  - Byte accept: acc = rx_valid & ~rx_valid_q (rx_valid_q registered). Level-held rx_valid = one byte.
//  - HDR: [7:4] cmd, [3:0] addr. cmd 4'h1 = WRITE, 4'h2 = CLR_ERR; all other cmd values illegal.
//  - Checksum: CHK must equal HDR ^ DATA (WRITE) or HDR ^ 8'h00 (CLR_ERR, DATA byte sent as any value, ignored
//    in checksum? no: CLR_ERR packet is still 4 bytes, CHK = HDR ^ DATA uniformly for both cmds).
//  - FSM (transitions on acc):
//    IDLE: byte==SYNC_BYTE -> HDR; other bytes discarded silently (no error).
//    HDR : latch HDR; legal cmd -> DATA; illegal cmd -> pkt_err, IDLE.
//    DATA: latch DATA -> CHK.
//    CHK : CHK==HDR^DATA -> execute, pkt_ok, IDLE; mismatch -> pkt_err, IDLE.
//  - Execute WRITE: next cycle after CHK acc: reg_wr_en=1, reg_addr=HDR[3:0], reg_wr_data=DATA, pkt_ok=1,
//    all for exactly one cycle. reg_addr/reg_wr_data hold last value otherwise.
//  - Execute CLR_ERR: err_count <= 0 and pkt_ok pulse next cycle; no reg_wr_en.
//  - Error latency: pkt_err asserted cycle after the offending acc (or timeout expiry); err_count
//    increments same cycle, saturates at 8'hFF (no wrap).
//  - Timeout: counter cleared on every acc and in IDLE; counts while state!=IDLE; reaching
//    TIMEOUT_CYCLES-1 -> pkt_err, err_count++, IDLE. acc in same cycle as expiry wins (byte consumed,
//    counter cleared, no error).
//  - SYNC_BYTE value in HDR/DATA/CHK positions is treated as ordinary data (no resync).
//  - busy = (state != IDLE), registered with state.
//  - reset_n low mid-packet: immediate return to IDLE, partial packet dropped, no pulse, err_count 0.
// TESTING
//  1 Bytes A5,13,5C,4F -> one cycle after 4th strobe: reg_wr_en=1, reg_addr=3, reg_wr_data=5C, pkt_ok=1.
//  2 Bytes A5,13,5C,00 -> pkt_err one pulse, err_count 0->1, no reg_wr_en; next valid packet still works.
//  3 Bytes A5,73 -> pkt_err after HDR, IDLE; then 00,11,A5,21,00,21 -> only junk ignored, CLR_ERR: err_count=0, pkt_ok.
//  4 A5,13 then idle 10400 cycles -> pkt_err at expiry, busy falls; strobe landing on expiry cycle -> no error.
//  5 rx_valid held high 5 cycles per byte -> identical results to 1-cycle strobes; 300 bad packets -> err_count=FF.
//  6 reset_n pulsed low after A5,13,5C -> all outputs 0, busy 0; following 4F ignored (IDLE, not SYNC).

Source files
------------

// File: rtl/uart_cmd_ctrl_if.sv
// Byte stream from the UART receiver and the register-write/status side of the command sequencer.
// rx_valid carries a new byte on each rising edge; output pulses (reg_wr_en, pkt_ok, pkt_err) last one cycle.
interface uart_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       reg_wr_en;
    logic [3:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       pkt_ok;
    logic       pkt_err;
    logic       busy;
    logic [7:0] err_count;
    logic [1:0] dbg_state;

    modport master (
        output rx_data, rx_valid,
        input  reg_wr_en, reg_addr, reg_wr_data, pkt_ok, pkt_err, busy, err_count, dbg_state
    );

    modport slave (
        input  rx_data, rx_valid,
        output reg_wr_en, reg_addr, reg_wr_data, pkt_ok, pkt_err, busy, err_count, dbg_state
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frames received bytes into SYNC/HDR/DATA/CHK packets, checks checksum and inter-byte timeout,
// and issues one-cycle config register writes; also owns the saturating RX error counter.
module uart_cmd_ctrl #(
    parameter int unsigned CLK_HZ        = 5_000_000,
    parameter int unsigned BAUD          = 9600,
    parameter int unsigned TIMEOUT_BYTES = 2,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input  logic            clock,
    input  logic            reset_n,
    uart_cmd_ctrl_if.slave  bus
);
    localparam int unsigned TIMEOUT_CYCLES = (CLK_HZ / BAUD) * 10 * TIMEOUT_BYTES;
    localparam int          TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]  CMD_WRITE      = 4'h1;
    localparam logic [3:0]  CMD_CLR_ERR    = 4'h2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               rx_valid_q;
    logic [7:0]         hdr_q, hdr_d;
    logic [7:0]         data_q, data_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               wr_en_q, wr_en_d;
    logic [3:0]         addr_q, addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               clr_d;
    logic               acc;
    logic               cmd_legal;
    logic               tmo_hit;

    // A level-held rx_valid counts as a single byte.
    assign acc       = bus.rx_valid & ~rx_valid_q;
    assign cmd_legal = (bus.rx_data[7:4] == CMD_WRITE) || (bus.rx_data[7:4] == CMD_CLR_ERR);
    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        data_d    = data_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        clr_d     = 1'b0;
        tmo_d     = (state_q == ST_IDLE || acc) ? '0 : tmo_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (acc && bus.rx_data == SYNC_BYTE) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (acc) begin
                    hdr_d = bus.rx_data;
                    if (cmd_legal) begin
                        state_d = ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (acc) begin
                    data_d  = bus.rx_data;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (acc) begin
                    state_d = ST_IDLE;
                    if (bus.rx_data == (hdr_q ^ data_q)) begin
                        ok_d = 1'b1;
                        if (hdr_q[7:4] == CMD_WRITE) begin
                            wr_en_d   = 1'b1;
                            addr_d    = hdr_q[3:0];
                            wr_data_d = data_q;
                        end else begin
                            clr_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte arriving on the expiry cycle wins over the timeout.
        if (state_q != ST_IDLE && !acc && tmo_hit) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
            tmo_d   = '0;
        end

        err_cnt_d = err_cnt_q;
        if (clr_d) begin
            err_cnt_d = 8'h00;
        end else if (err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'h01;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rx_valid_q <= 1'b0;
            hdr_q      <= 8'h00;
            data_q     <= 8'h00;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= 4'h0;
            wr_data_q  <= 8'h00;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_cnt_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= bus.rx_valid;
            hdr_q      <= hdr_d;
            data_q     <= data_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_addr    = addr_q;
    assign bus.reg_wr_data = wr_data_q;
    assign bus.pkt_ok      = ok_q;
    assign bus.pkt_err     = err_q;
    assign bus.busy        = busy_q;
    assign bus.err_count   = err_cnt_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed and random byte streams into uart_cmd_ctrl, checked every cycle against a
// packet-buffer model of the command protocol.
module tb_uart_cmd_ctrl;
    localparam int unsigned TIMEOUT_CYCLES = (5_000_000 / 9600) * 10 * 2;
    localparam logic [7:0]  SYNC           = 8'hA5;

    logic clock;
    logic reset_n;
    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: buffered bytes of the packet in progress plus visible output state.
    logic [7:0] pkt_q[$];
    int         m_cnt;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    logic       m_wr, m_ok, m_err;
    int         elapsed;
    logic       prev_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_error();
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] hdr, dat, ck;
        if (pkt_q.size() == 0) begin
            if (b == SYNC) pkt_q.push_back(b);
        end else begin
            pkt_q.push_back(b);
            if (pkt_q.size() == 2) begin
                if (!(b[7:4] == 4'h1 || b[7:4] == 4'h2)) begin
                    model_error();
                    pkt_q.delete();
                end
            end else if (pkt_q.size() == 4) begin
                hdr = pkt_q[1];
                dat = pkt_q[2];
                ck  = pkt_q[3];
                if (ck == (hdr ^ dat)) begin
                    m_ok = 1'b1;
                    if (hdr[7:4] == 4'h1) begin
                        m_wr   = 1'b1;
                        m_addr = hdr[3:0];
                        m_data = dat;
                    end else begin
                        m_cnt = 0;
                    end
                end else begin
                    model_error();
                end
                pkt_q.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("reg_wr_en",   32'(bus.reg_wr_en),   32'(m_wr));
        chk("pkt_ok",      32'(bus.pkt_ok),      32'(m_ok));
        chk("pkt_err",     32'(bus.pkt_err),     32'(m_err));
        chk("reg_addr",    32'(bus.reg_addr),    32'(m_addr));
        chk("reg_wr_data", 32'(bus.reg_wr_data), 32'(m_data));
        chk("err_count",   32'(bus.err_count),   32'(m_cnt));
        chk("busy",        32'(bus.busy),        32'(pkt_q.size() != 0));
    endtask

    // One clock edge: advance the model by what the edge should do, then compare.
    task automatic tick();
        logic acc;
        @(posedge clock);
        m_wr  = 1'b0;
        m_ok  = 1'b0;
        m_err = 1'b0;
        acc = bus.rx_valid && !prev_valid;
        prev_valid = bus.rx_valid;
        if (acc) begin
            elapsed = 0;
            model_byte(bus.rx_data);
        end else if (pkt_q.size() != 0) begin
            elapsed++;
            if (elapsed == int'(TIMEOUT_CYCLES)) begin
                model_error();
                pkt_q.delete();
            end
        end
        #1;
        check_all();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(negedge clock);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        @(negedge clock);
        bus.rx_valid = 1'b0;
        for (int i = 0; i <= gap; i++) tick();
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] d, input logic [7:0] c, input int hold);
        send_byte(SYNC, hold, 0);
        send_byte(h, hold, 0);
        send_byte(d, hold, 0);
        send_byte(c, hold, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        pkt_q.delete();
        m_cnt = 0; m_addr = 4'h0; m_data = 8'h00;
        m_wr = 1'b0; m_ok = 1'b0; m_err = 1'b0;
        elapsed = 0;
        prev_valid = 1'b0;
        #1;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] h, d, c, b;
        int kind, hold;

        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        do_reset();
        tick();

        // Basic write
        send_pkt(8'h13, 8'h5C, 8'h4F, 1);
        chk("t1_addr", 32'(bus.reg_addr), 32'h3);
        chk("t1_data", 32'(bus.reg_wr_data), 32'h5C);

        // Bad checksum, then a good packet
        send_pkt(8'h13, 8'h5C, 8'h00, 1);
        chk("t2_errcnt", 32'(bus.err_count), 32'h1);
        send_pkt(8'h13, 8'h5C, 8'h4F, 1);

        // Illegal command, junk, then CLR_ERR
        send_byte(SYNC, 1, 0);
        send_byte(8'h73, 1, 0);
        chk("t3_errcnt", 32'(bus.err_count), 32'h2);
        send_byte(8'h00, 1, 1);
        send_byte(8'h11, 1, 1);
        send_pkt(8'h21, 8'h00, 8'h21, 1);
        chk("t3_clr", 32'(bus.err_count), 32'h0);

        // Inter-byte timeout
        send_byte(SYNC, 1, 0);
        send_byte(8'h13, 1, 0);
        repeat (TIMEOUT_CYCLES) tick();
        chk("t4_errcnt", 32'(bus.err_count), 32'h1);
        chk("t4_busy", 32'(bus.busy), 32'h0);

        // Byte landing exactly on the expiry cycle is consumed
        send_byte(SYNC, 1, 0);
        send_byte(8'h13, 1, 0);
        while (elapsed < int'(TIMEOUT_CYCLES) - 1) tick();
        send_byte(8'h5C, 1, 0);
        send_byte(8'h4F, 1, 0);
        chk("t4_edge_errcnt", 32'(bus.err_count), 32'h1);
        chk("t4_edge_data", 32'(bus.reg_wr_data), 32'h5C);

        // Held strobes and error counter saturation
        send_pkt(8'h1A, 8'h33, 8'h1A ^ 8'h33, 5);
        for (int i = 0; i < 300; i++) begin
            send_byte(SYNC, 5, 0);
            send_byte(8'h73, 5, 0);
        end
        chk("t5_sat", 32'(bus.err_count), 32'hFF);

        // Reset mid-packet
        send_byte(SYNC, 1, 0);
        send_byte(8'h13, 1, 0);
        send_byte(8'h5C, 1, 0);
        do_reset();
        send_byte(8'h4F, 1, 2);
        chk("t6_busy", 32'(bus.busy), 32'h0);
        chk("t6_errcnt", 32'(bus.err_count), 32'h0);

        // Random packets
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 4);
            hold = $urandom_range(1, 5);
            d    = 8'($urandom_range(0, 255));
            case (kind)
                0: h = {4'h1, 4'($urandom_range(0, 15))};
                1: h = {4'h2, 4'($urandom_range(0, 15))};
                2: h = {4'h1, 4'($urandom_range(0, 15))};
                3: h = {4'($urandom_range(3, 15)), 4'($urandom_range(0, 15))};
                default: h = 8'h00;
            endcase
            c = h ^ d;
            if (kind == 2) c = c ^ 8'($urandom_range(1, 255));
            if (kind == 4) begin
                b = 8'($urandom_range(0, 255));
                send_byte(b, hold, $urandom_range(0, 3));
            end else if (kind == 3) begin
                send_byte(SYNC, hold, $urandom_range(0, 3));
                send_byte(h, hold, $urandom_range(0, 3));
            end else begin
                send_byte(SYNC, hold, $urandom_range(0, 3));
                send_byte(h, hold, $urandom_range(0, 3));
                send_byte(d, hold, $urandom_range(0, 3));
                send_byte(c, hold, $urandom_range(0, 3));
            end
        end
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
